// File: rtl/mudi_unit.sv
// mudi_unit: E-stage multiply/divide responder holding the HI/LO registers.
// mult/multu/div/divu hold busy for a fixed number of cycles and commit
// HI/LO together at the end. mthi/mtlo write straight through.
// Optional build macro MUDI_MADD_EN turns op 110 into madd
// ({hi,lo} += signed a*b). Without the macro, op 110 is a reserved nop.
//
// Handshake: an instruction is accepted on a rising edge when start=1,
// req=0 and busy=0. A start that arrives while busy, or together with req,
// is dropped without side effects. busy=1 means HI/LO hold their old values
// and the stall unit must keep further mult/div/mfhi/mflo from issuing.
module mudi_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        req,
  input  logic        sel,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] rd_data
);

  typedef enum logic {IDLE, BUSY} stateT;

  localparam logic [3:0] MULT_N = MULT_CYCLES[3:0];
  localparam logic [3:0] DIV_N  = DIV_CYCLES[3:0];

  stateT        state, stateNext;
  logic [3:0]   cnt, cntNext;
  logic [31:0]  pHi, pLo, pHiNext, pLoNext;
  logic [31:0]  hiNext, loNext;
  logic         acc;

  logic signed [63:0] sProd;
  logic [63:0]        uProd;
  logic [31:0]        absA, absB, divisor, udivisor;
  logic [31:0]        qMag, rMag, sQuo, sRem, uQuo, uRem;
`ifdef MUDI_MADD_EN
  logic [63:0]        macc;
`endif

  assign busy    = (state == BUSY);
  assign acc     = start & ~req & ~busy;
  assign rd_data = sel ? hi : lo;

  // Arithmetic results for the operands presented this cycle. Signed divide
  // is done on magnitudes so truncation toward zero and a dividend-signed
  // remainder fall out directly; 0x80000000 / -1 wraps back to 0x80000000.
  always_comb begin
    sProd    = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    uProd    = {32'd0, a} * {32'd0, b};
    absA     = a[31] ? (32'd0 - a) : a;
    absB     = b[31] ? (32'd0 - b) : b;
    divisor  = (b == 32'd0) ? 32'd1 : absB;
    udivisor = (b == 32'd0) ? 32'd1 : b;
    qMag     = absA / divisor;
    rMag     = absA % divisor;
    sQuo     = (a[31] ^ b[31]) ? (32'd0 - qMag) : qMag;
    sRem     = a[31] ? (32'd0 - rMag) : rMag;
    uQuo     = a / udivisor;
    uRem     = a % udivisor;
`ifdef MUDI_MADD_EN
    macc     = {hi, lo} + sProd;
`endif
  end

  // Next-state logic: accept in IDLE, count down in BUSY, commit at cnt==1.
  always_comb begin
    stateNext = state;
    cntNext   = cnt;
    pHiNext   = pHi;
    pLoNext   = pLo;
    hiNext    = hi;
    loNext    = lo;
    case (state)
      IDLE: begin
        if (acc) begin
          case (op)
            3'b000: begin
              {pHiNext, pLoNext} = sProd;
              cntNext   = MULT_N;
              stateNext = BUSY;
            end
            3'b001: begin
              {pHiNext, pLoNext} = uProd;
              cntNext   = MULT_N;
              stateNext = BUSY;
            end
            3'b010: begin
              // Divide by zero still costs the full period but keeps HI/LO.
              if (b == 32'd0) {pHiNext, pLoNext} = {hi, lo};
              else            {pHiNext, pLoNext} = {sRem, sQuo};
              cntNext   = DIV_N;
              stateNext = BUSY;
            end
            3'b011: begin
              if (b == 32'd0) {pHiNext, pLoNext} = {hi, lo};
              else            {pHiNext, pLoNext} = {uRem, uQuo};
              cntNext   = DIV_N;
              stateNext = BUSY;
            end
            3'b100: hiNext = a;
            3'b101: loNext = a;
`ifdef MUDI_MADD_EN
            3'b110: begin
              {pHiNext, pLoNext} = macc;
              cntNext   = MULT_N;
              stateNext = BUSY;
            end
`endif
            default: ;
          endcase
        end
      end
      BUSY: begin
        cntNext = cnt - 4'd1;
        if (cnt == 4'd1) begin
          hiNext    = pHi;
          loNext    = pLo;
          cntNext   = 4'd0;
          stateNext = IDLE;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  // State, counter, pending result and architectural HI/LO registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= 4'd0;
      pHi   <= 32'd0;
      pLo   <= 32'd0;
      hi    <= 32'd0;
      lo    <= 32'd0;
    end else begin
      state <= stateNext;
      cnt   <= cntNext;
      pHi   <= pHiNext;
      pLo   <= pLoNext;
      hi    <= hiNext;
      lo    <= loNext;
    end
  end

endmodule

// File: tb/tb_mudi_unit.sv
// Bench for mudi_unit: directed vector table, mid-operation reset sequence,
// then randomized operations checked against a 64-bit arithmetic model.
module tb_mudi_unit;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] a = 32'd0;
  logic [31:0] b = 32'd0;
  logic        req = 1'b0;
  logic        sel = 1'b0;
  logic        busy;
  logic [31:0] hi, lo, rdData;

  int nCompared = 0;
  int nMismatched = 0;

  logic [31:0] mdlHi = 32'd0;
  logic [31:0] mdlLo = 32'd0;
  logic [63:0] expQ[$];

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        req;
    logic [31:0] expHi;
    logic [31:0] expLo;
    int          expBusy;
  } vecT;

  vecT vec[14];

  mudi_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
    .req(req), .sel(sel), .busy(busy), .hi(hi), .lo(lo), .rd_data(rdData)
  );

  // Clock.
  always #5 clk = ~clk;

  // The stall unit must never present start while busy.
  always @(posedge clk) begin
    if (rst_n && start && busy) begin
      nMismatched++;
      $display("FAIL startWhileBusy: start seen with busy=1 at %0t", $time);
    end
  end

  // Watchdog.
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic checkRegs(input string name, input logic [31:0] eh, input logic [31:0] el);
    check({name, ".hi"}, hi, eh);
    check({name, ".lo"}, lo, el);
    sel = 1'b0; #1;
    check({name, ".rdLo"}, rdData, el);
    sel = 1'b1; #1;
    check({name, ".rdHi"}, rdData, eh);
    sel = 1'b0;
  endtask

  // Issue one instruction, scramble the operand buses afterwards, and count
  // the cycles busy stays high.
  task automatic runOp(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                       input logic r, output int cyc);
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y; req = r;
    @(posedge clk); #1;
    start = 1'b0; req = 1'b0; a = $urandom; b = $urandom;
    cyc = 0;
    while (busy && cyc < 64) begin
      cyc++;
      @(posedge clk); #1;
    end
    if (cyc >= 64) begin
      nCompared++;
      nMismatched++;
      $display("FAIL busyTimeout: busy still high after %0d cycles", cyc);
    end
  endtask

  // Reference model straight from the arithmetic rules, using 64-bit ints.
  task automatic modelOp(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                         input logic r, output int eb);
    longint sx, sy, q, rm;
    logic [63:0] p;
    logic [31:0] eh, el;
    eh = mdlHi; el = mdlLo; eb = 0;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    if (!r) begin
      case (o)
        3'd0: begin p = sx * sy; {eh, el} = p; eb = MC; end
        3'd1: begin p = {32'd0, x} * {32'd0, y}; {eh, el} = p; eb = MC; end
        3'd2: begin
          eb = DC;
          if (y != 0) begin q = sx / sy; rm = sx % sy; el = q[31:0]; eh = rm[31:0]; end
        end
        3'd3: begin
          eb = DC;
          if (y != 0) begin el = x / y; eh = x % y; end
        end
        3'd4: eh = x;
        3'd5: el = x;
`ifdef MUDI_MADD_EN
        3'd6: begin p = {mdlHi, mdlLo} + 64'(sx * sy); {eh, el} = p; eb = MC; end
`endif
        default: ;
      endcase
    end
    mdlHi = eh; mdlLo = el;
    expQ.push_back({eh, el});
  endtask

  initial begin
    int cyc, eb;
    logic [63:0] e;
    logic [2:0] o;
    logic [31:0] x, y;
    logic r;

    vec[0]  = '{3'd4, 32'h12345678, 32'h0, 1'b1, 32'h0, 32'h0, 0};
    vec[1]  = '{3'd4, 32'h12345678, 32'h0, 1'b0, 32'h12345678, 32'h0, 0};
    vec[2]  = '{3'd0, 32'hFFFFFFFD, 32'd5, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFF1, MC};
    vec[3]  = '{3'd2, 32'hFFFFFFF9, 32'd2, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFD, DC};
    vec[4]  = '{3'd3, 32'd7, 32'd2, 1'b0, 32'd1, 32'd3, DC};
    vec[5]  = '{3'd2, 32'h80000000, 32'hFFFFFFFF, 1'b0, 32'h0, 32'h80000000, DC};
    vec[6]  = '{3'd2, 32'd5, 32'd0, 1'b0, 32'h0, 32'h80000000, DC};
    vec[7]  = '{3'd0, 32'd3, 32'd3, 1'b1, 32'h0, 32'h80000000, 0};
    vec[8]  = '{3'd5, 32'hFFFFFFFF, 32'h0, 1'b0, 32'h0, 32'hFFFFFFFF, 0};
`ifdef MUDI_MADD_EN
    vec[9]  = '{3'd6, 32'd1, 32'd1, 1'b0, 32'h1, 32'h0, MC};
    vec[10] = '{3'd7, 32'd9, 32'd9, 1'b0, 32'h1, 32'h0, 0};
    vec[11] = '{3'd3, 32'd9, 32'd0, 1'b0, 32'h1, 32'h0, DC};
`else
    vec[9]  = '{3'd6, 32'd1, 32'd1, 1'b0, 32'h0, 32'hFFFFFFFF, 0};
    vec[10] = '{3'd7, 32'd9, 32'd9, 1'b0, 32'h0, 32'hFFFFFFFF, 0};
    vec[11] = '{3'd3, 32'd9, 32'd0, 1'b0, 32'h0, 32'hFFFFFFFF, DC};
`endif
    vec[12] = '{3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'hFFFFFFFE, 32'h00000001, MC};
    vec[13] = '{3'd2, 32'd7, 32'hFFFFFFFE, 1'b0, 32'd1, 32'hFFFFFFFD, DC};

    // Reset.
    repeat (3) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    check("reset.busy", {31'd0, busy}, 32'd0);
    checkRegs("reset", 32'd0, 32'd0);

    // Directed vectors.
    for (int i = 0; i < 14; i++) begin
      runOp(vec[i].op, vec[i].a, vec[i].b, vec[i].req, cyc);
      check($sformatf("vec%0d.busyCycles", i), 32'(cyc), 32'(vec[i].expBusy));
      checkRegs($sformatf("vec%0d", i), vec[i].expHi, vec[i].expLo);
    end

    // Reset asserted in the third busy cycle of a multu aborts it.
    @(negedge clk);
    start = 1'b1; op = 3'd1; a = 32'hFFFFFFFF; b = 32'hFFFFFFFF;
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("abort.busyBefore", {31'd0, busy}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("abort.busy", {31'd0, busy}, 32'd0);
    check("abort.hi", hi, 32'd0);
    check("abort.lo", lo, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    check("abort.busyLater", {31'd0, busy}, 32'd0);
    checkRegs("abort.later", 32'd0, 32'd0);
    mdlHi = 32'd0; mdlLo = 32'd0;

    // Randomized operations against the model.
    for (int i = 0; i < 60; i++) begin
      o = 3'($urandom_range(0, 7));
      x = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) : $urandom;
      case ($urandom_range(0, 5))
        0: y = 32'd0;
        1: y = 32'($urandom_range(1, 9));
        2: y = 32'hFFFFFFFF;
        default: y = $urandom;
      endcase
      r = ($urandom_range(0, 3) == 0);
      modelOp(o, x, y, r, eb);
      runOp(o, x, y, r, cyc);
      e = expQ.pop_front();
      check($sformatf("rnd%0d.op%0d.busyCycles", i, o), 32'(cyc), 32'(eb));
      checkRegs($sformatf("rnd%0d.op%0d", i, o), e[63:32], e[31:0]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
